pipeline_id: RTL and testbench
==============================

Name: pipeline_id

Overview:
- Instruction-decode (ID) stage of the in-order RV32I pipeline.
- Decodes instructionD into an ALU operation code, destination register and write enable.
- Holds the 32x32 integer register file: read ports for rs1/rs2, write port driven by the writeback (W) stage.
- Sits between the IF/ID and ID/EX pipeline registers; this block contains no pipeline register itself.

Parameters:
- XLEN, 32, data width of registers and operands.
- NREGS, 32, number of architectural registers (index width 5).

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- instructionD  input  32  instruction in decode.
- regWriteEnW  input  1  writeback write enable.
- rdW  input  5  writeback destination index.
- writeBackDataW  input  32  writeback data.
- aluOperationD  output  5  decoded ALU operation code.
- rs1D  output  32  value of register instructionD[19:15].
- rs2D  output  32  value of register instructionD[24:20] (see Optional Feature).
- regWriteEnD  output  1  instruction writes rd.
- rdD  output  5  destination index.

Behaviour:
- Register file:
  - 32 entries; x0 reads 0 always.
  - Write on rising clk when regWriteEnW=1 and rdW!=0; writes to x0 are discarded.
  - resetn low clears all entries asynchronously.
- Reads are combinational with W->D bypass: if regWriteEnW=1, rdW!=0 and rdW equals the read index, output writeBackDataW in the same cycle.
- Decode is purely combinational (0-cycle latency).
- While resetn=0, all outputs are 0.
- ALU codes (5 bit):
  - NOP=0, ADD=1, SUB=2, SLL=3, SLT=4, SLTU=5, XOR=6, SRL=7, SRA=8, OR=9, AND=10, PASSB=11.
  - BEQ=12, BNE=13, BLT=14, BGE=15, BLTU=16, BGEU=17.
  - 18-31 reserved, never produced.
- Opcode handling:
  - OP (0110011): funct3/funct7 select ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND. funct7 must be 0000000, or 0100000 for SUB/SRA only; any other combination is illegal.
  - OP-IMM (0010011): same mapping, no SUB. SLLI needs funct7=0000000; SRLI/SRAI need funct7 0000000/0100000; otherwise illegal.
  - LUI: PASSB.
  - AUIPC, JAL, JALR, LOAD, STORE: ADD.
  - BRANCH: by funct3. funct3 010/011 is illegal.
- regWriteEnD=1 for OP, OP-IMM, LUI, AUIPC, JAL, JALR, LOAD; 0 for STORE, BRANCH, SYSTEM, FENCE and illegal encodings.
- rdD = instructionD[11:7] when regWriteEnD=1, else 0. rd=x0 still yields regWriteEnD=1, rdD=0.
- Illegal/unknown encodings (e.g. 0x00000000–0x00000003): aluOperationD=NOP, regWriteEnD=0, rdD=0. rs1D/rs2D still reflect the index fields.
- Reset deasserted mid-stream: the first decoded instruction after release sees an all-zero register file.

Optional Feature:
- Macro PIPELINE_ID_IMM_OPERAND_EN.
- Defined: rs2D carries the sign-extended immediate instead of the register value:
  - I-imm for OP-IMM/LOAD/JALR.
  - S-imm for STORE.
  - U-imm (imm<<12) for LUI/AUIPC.
  - J-imm for JAL.
  - Register value for OP/BRANCH.
- Undefined: rs2D is always the rs2 register read value.

Decomposition:
- Package pipeline_pkg holds:
  - ALU operation code constants (5 bit).
  - RV32I opcode constants (OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, SYSTEM, FENCE).
  - funct3 constants.
- One sub-module, pipeline_regfile: 32x32 storage, async clear, two bypassed read ports, one write port.
- The decoder stays inline in pipeline_id.

Test Plan:
- Reset low 1 cycle, instructionD=0x00100293 -> all outputs 0. After release: aluOperationD=1, regWriteEnD=1, rdD=5, rs1D=0.
- Write x5=1, then x6=2 via W port. instructionD=0x006283b3 -> aluOperationD=1, rs1D=1, rs2D=2, rdD=7, regWriteEnD=1. instructionD=0x406283b3 -> aluOperationD=2, same operands.
- instructionD = 0x00000000, 0x00000001, 0x00000002, 0x00000003 in turn -> aluOperationD=0, regWriteEnD=0, rdD=0 for each.
- Bypass: instructionD=0x006283b3, same cycle regWriteEnW=1, rdW=5, writeBackDataW=0xDEADBEEF -> rs1D=0xDEADBEEF combinationally.
- x0 protection: write rdW=0 with 0x12345678, then read via instructionD=0x00000033 (add x0,x0,x0) -> rs1D=rs2D=0, rdD=0, regWriteEnD=1.
- Reset mid-run: after x5=1 is written, pulse resetn low asynchronously, re-decode 0x006283b3 -> rs1D=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared constants for the RV32I decode stage: ALU operation codes,
// base opcodes, funct3/funct7 values and immediate extraction helpers.
package pipeline_pkg;

  localparam int XLEN      = 32;
  localparam int NREGS     = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic [4:0] {
    ALU_NOP   = 5'd0,
    ALU_ADD   = 5'd1,
    ALU_SUB   = 5'd2,
    ALU_SLL   = 5'd3,
    ALU_SLT   = 5'd4,
    ALU_SLTU  = 5'd5,
    ALU_XOR   = 5'd6,
    ALU_SRL   = 5'd7,
    ALU_SRA   = 5'd8,
    ALU_OR    = 5'd9,
    ALU_AND   = 5'd10,
    ALU_PASSB = 5'd11,
    ALU_BEQ   = 5'd12,
    ALU_BNE   = 5'd13,
    ALU_BLT   = 5'd14,
    ALU_BGE   = 5'd15,
    ALU_BLTU  = 5'd16,
    ALU_BGEU  = 5'd17
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  function automatic logic [31:0] immI(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] immS(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [31:0] immU(input logic [31:0] instr);
    return {instr[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] immJ(input logic [31:0] instr);
    return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/pipeline_id_if.sv
// Decode-stage bus: instruction in, writeback port in, decoded fields out.
import pipeline_pkg::*;

interface pipeline_id_if #(parameter int DATA_W = XLEN) ();
  // No valid/ready: every field is level-sampled each cycle; stalls and
  // bubbles are handled by the IF/ID and ID/EX registers around this stage.
  logic [31:0]          instructionD;
  logic                 regWriteEnW;
  logic [REG_IDX_W-1:0] rdW;
  logic [DATA_W-1:0]    writeBackDataW;
  logic [4:0]           aluOperationD;
  logic [DATA_W-1:0]    rs1D;
  logic [DATA_W-1:0]    rs2D;
  logic                 regWriteEnD;
  logic [REG_IDX_W-1:0] rdD;

  modport master (
    output instructionD, regWriteEnW, rdW, writeBackDataW,
    input  aluOperationD, rs1D, rs2D, regWriteEnD, rdD
  );

  modport slave (
    input  instructionD, regWriteEnW, rdW, writeBackDataW,
    output aluOperationD, rs1D, rs2D, regWriteEnD, rdD
  );
endinterface

// File: rtl/pipeline_regfile.sv
// Integer register file: x0 hardwired to zero, asynchronous clear, two
// combinational read ports that bypass a same-cycle writeback.
import pipeline_pkg::*;

module pipeline_regfile #(
  parameter int DATA_W = XLEN,
  parameter int DEPTH  = NREGS,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wrEn,
  input  logic [IDX_W-1:0]  wrIdx,
  input  logic [DATA_W-1:0] wrData,
  input  logic [IDX_W-1:0]  rdIdxA,
  output logic [DATA_W-1:0] rdDataA,
  input  logic [IDX_W-1:0]  rdIdxB,
  output logic [DATA_W-1:0] rdDataB
);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wrLive;

  assign wrLive = wrEn && (wrIdx != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wrLive) begin
      regs[wrIdx] <= wrData;
    end
  end

  // x0 is forced to zero on read as well, so storage entry 0 is never trusted.
  always_comb begin
    rdDataA = '0;
    if (rdIdxA != '0) begin
      rdDataA = (wrLive && (wrIdx == rdIdxA)) ? wrData : regs[rdIdxA];
    end
  end

  always_comb begin
    rdDataB = '0;
    if (rdIdxB != '0) begin
      rdDataB = (wrLive && (wrIdx == rdIdxB)) ? wrData : regs[rdIdxB];
    end
  end

endmodule

// File: rtl/pipeline_id.sv
// RV32I instruction-decode stage: combinational decoder plus register file.
// Optional macro PIPELINE_ID_IMM_OPERAND_EN routes the immediate onto rs2D.
import pipeline_pkg::*;

module pipeline_id #(
  parameter int DATA_W = XLEN,
  parameter int DEPTH  = NREGS
) (
  input  logic         clk,
  input  logic         resetn,
  pipeline_id_if.slave idBus
);

  logic [31:0]          instr;
  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [6:0]           funct7;
  logic [REG_IDX_W-1:0] rs1Idx;
  logic [REG_IDX_W-1:0] rs2Idx;
  logic [REG_IDX_W-1:0] rdField;

  assign instr   = idBus.instructionD;
  assign opcode  = instr[6:0];
  assign rdField = instr[11:7];
  assign funct3  = instr[14:12];
  assign rs1Idx  = instr[19:15];
  assign rs2Idx  = instr[24:20];
  assign funct7  = instr[31:25];

  logic [DATA_W-1:0] rs1Val;
  logic [DATA_W-1:0] rs2Val;

  pipeline_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (REG_IDX_W)
  ) u_regfile (
    .clk     (clk),
    .resetn  (resetn),
    .wrEn    (idBus.regWriteEnW),
    .wrIdx   (idBus.rdW),
    .wrData  (idBus.writeBackDataW),
    .rdIdxA  (rs1Idx),
    .rdDataA (rs1Val),
    .rdIdxB  (rs2Idx),
    .rdDataB (rs2Val)
  );

  alu_op_e aluOp;
  logic    writesRd;
  logic    legal;

  always_comb begin
    aluOp    = ALU_NOP;
    writesRd = 1'b0;
    legal    = 1'b1;
    unique case (opcode)
      OPC_OP: begin
        writesRd = 1'b1;
        case (funct3)
          F3_ADD_SUB: aluOp = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
          F3_SLL:     aluOp = ALU_SLL;
          F3_SLT:     aluOp = ALU_SLT;
          F3_SLTU:    aluOp = ALU_SLTU;
          F3_XOR:     aluOp = ALU_XOR;
          F3_SRL_SRA: aluOp = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          F3_OR:      aluOp = ALU_OR;
          default:    aluOp = ALU_AND;
        endcase
        if (funct7 != F7_BASE &&
            !(funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA))) begin
          legal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        writesRd = 1'b1;
        case (funct3)
          F3_ADD_SUB: aluOp = ALU_ADD;
          F3_SLL:     aluOp = ALU_SLL;
          F3_SLT:     aluOp = ALU_SLT;
          F3_SLTU:    aluOp = ALU_SLTU;
          F3_XOR:     aluOp = ALU_XOR;
          F3_SRL_SRA: aluOp = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          F3_OR:      aluOp = ALU_OR;
          default:    aluOp = ALU_AND;
        endcase
        // Only the shift forms carry funct7; the rest use those bits as immediate.
        if (funct3 == F3_SLL && funct7 != F7_BASE) legal = 1'b0;
        if (funct3 == F3_SRL_SRA && funct7 != F7_BASE && funct7 != F7_ALT) legal = 1'b0;
      end
      OPC_LUI: begin
        writesRd = 1'b1;
        aluOp    = ALU_PASSB;
      end
      OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD: begin
        writesRd = 1'b1;
        aluOp    = ALU_ADD;
      end
      OPC_STORE: aluOp = ALU_ADD;
      OPC_BRANCH: begin
        case (funct3)
          F3_BEQ:  aluOp = ALU_BEQ;
          F3_BNE:  aluOp = ALU_BNE;
          F3_BLT:  aluOp = ALU_BLT;
          F3_BGE:  aluOp = ALU_BGE;
          F3_BLTU: aluOp = ALU_BLTU;
          F3_BGEU: aluOp = ALU_BGEU;
          default: legal = 1'b0;
        endcase
      end
      OPC_SYSTEM, OPC_FENCE: aluOp = ALU_NOP;
      default: legal = 1'b0;
    endcase
    // The bottom of the encoding space (all bits above [1:0] clear) is treated
    // as illegal so that zeroed instruction memory never decodes to a load.
    if (instr[31:2] == '0) legal = 1'b0;
    if (!legal) begin
      aluOp    = ALU_NOP;
      writesRd = 1'b0;
    end
  end

  logic [DATA_W-1:0] operandB;

`ifdef PIPELINE_ID_IMM_OPERAND_EN
  always_comb begin
    operandB = rs2Val;
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: operandB = DATA_W'(immI(instr));
      OPC_STORE:                      operandB = DATA_W'(immS(instr));
      OPC_LUI, OPC_AUIPC:             operandB = DATA_W'(immU(instr));
      OPC_JAL:                        operandB = DATA_W'(immJ(instr));
      default:                        operandB = rs2Val;
    endcase
  end
`else
  assign operandB = rs2Val;
`endif

  // Everything is forced to zero while reset is held, including bypassed data.
  assign idBus.aluOperationD = resetn ? aluOp    : ALU_NOP;
  assign idBus.regWriteEnD   = resetn && writesRd;
  assign idBus.rdD           = (resetn && writesRd) ? rdField : '0;
  assign idBus.rs1D          = resetn ? rs1Val   : '0;
  assign idBus.rs2D          = resetn ? operandB : '0;

endmodule

// File: tb/tb_pipeline_id.sv
// Self-checking bench for pipeline_id: directed cases followed by random
// instructions and writebacks compared against an architectural model.
module tb_pipeline_id;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  pipeline_id_if bus ();

  pipeline_id dut (
    .clk    (clk),
    .resetn (resetn),
    .idBus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural model state
  logic [31:0] mregs [32];
  logic [4:0]  op_tab [8];
  logic [4:0]  br_tab [8];
  logic [31:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
  endtask

  // Advance one clock; the model commits the writeback seen at the edge.
  task automatic step();
    @(posedge clk);
    if (resetn && bus.regWriteEnW && bus.rdW != 5'd0) mregs[bus.rdW] = bus.writeBackDataW;
    #1;
  endtask

  task automatic drive_w(input logic en, input logic [4:0] rd, input logic [31:0] data);
    bus.regWriteEnW    = en;
    bus.rdW            = rd;
    bus.writeBackDataW = data;
  endtask

  // Returns {writesRd, aluOp} from the instruction-set rules.
  function automatic logic [5:0] ref_decode(input logic [31:0] ins);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    if (ins < 32'd4) return 6'd0;
    case (opc)
      7'b0110011: begin
        if (f7 == 7'h00) return {1'b1, op_tab[f3]};
        if (f7 == 7'h20 && f3 == 3'd0) return {1'b1, 5'd2};
        if (f7 == 7'h20 && f3 == 3'd5) return {1'b1, 5'd8};
        return 6'd0;
      end
      7'b0010011: begin
        if (f3 == 3'd1 && f7 != 7'h00) return 6'd0;
        if (f3 == 3'd5) begin
          if (f7 == 7'h00) return {1'b1, 5'd7};
          if (f7 == 7'h20) return {1'b1, 5'd8};
          return 6'd0;
        end
        return {1'b1, op_tab[f3]};
      end
      7'b0110111: return {1'b1, 5'd11};
      7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011: return {1'b1, 5'd1};
      7'b0100011: return {1'b0, 5'd1};
      7'b1100011: return (f3 == 3'd2 || f3 == 3'd3) ? 6'd0 : {1'b0, br_tab[f3]};
      default: return 6'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (bus.regWriteEnW && bus.rdW == idx) return bus.writeBackDataW;
    return mregs[idx];
  endfunction

  function automatic logic [31:0] ref_operand_b(input logic [31:0] ins);
    logic [31:0] v;
    v = ref_read(ins[24:20]);
`ifdef PIPELINE_ID_IMM_OPERAND_EN
    case (ins[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: v = 32'($signed(ins) >>> 20);
      7'b0100011: v = (32'($signed(ins) >>> 20) & ~32'h1F) | 32'(ins[11:7]);
      7'b0110111, 7'b0010111: v = ins & 32'hFFFF_F000;
      7'b1101111: v = (ins[31] ? 32'hFFF0_0000 : 32'd0) | (32'(ins[19:12]) << 12)
                      | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      default: v = ref_read(ins[24:20]);
    endcase
`endif
    return v;
  endfunction

  // Queue the expected outputs for the current inputs, then compare in order.
  task automatic check_model(input string tag);
    logic [5:0]  d;
    logic [31:0] ins;
    ins = bus.instructionD;
    d   = ref_decode(ins);
    if (!resetn) begin
      repeat (5) exp_q.push_back(32'd0);
    end else begin
      exp_q.push_back(32'(d[4:0]));
      exp_q.push_back(32'(d[5]));
      exp_q.push_back(d[5] ? 32'(ins[11:7]) : 32'd0);
      exp_q.push_back(ref_read(ins[19:15]));
      exp_q.push_back(ref_operand_b(ins));
    end
    chk({tag, ".alu"}, 32'(bus.aluOperationD), exp_q.pop_front());
    chk({tag, ".we"},  32'(bus.regWriteEnD),   exp_q.pop_front());
    chk({tag, ".rd"},  32'(bus.rdD),           exp_q.pop_front());
    chk({tag, ".rs1"}, bus.rs1D,               exp_q.pop_front());
    chk({tag, ".rs2"}, bus.rs2D,               exp_q.pop_front());
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [11];
    logic [31:0] ins;
    int          sel;
    opcs = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
             7'b1100011, 7'b0000011, 7'b0100011, 7'b1110011, 7'b0001111};
    if ($urandom_range(0, 19) == 0) return 32'($urandom_range(0, 3));
    ins = $urandom;
    sel = $urandom_range(0, 11);
    if (sel < 11) ins[6:0] = opcs[sel];
    case ($urandom_range(0, 2))
      0: ins[31:25] = 7'h00;
      1: ins[31:25] = 7'h20;
      default: ;
    endcase
    return ins;
  endfunction

  initial begin
    logic [31:0] zero_words [4];
    checks   = 0;
    failures = 0;
    op_tab = '{5'd1, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd9, 5'd10};
    br_tab = '{5'd12, 5'd13, 5'd0, 5'd0, 5'd14, 5'd15, 5'd16, 5'd17};
    zero_words = '{32'h0, 32'h1, 32'h2, 32'h3};
    model_clear();

    // Held in reset: all outputs zero.
    resetn = 1'b0;
    bus.instructionD = 32'h0010_0293;
    drive_w(1'b0, 5'd0, 32'd0);
    step();
    step();
    chk("rst.alu", 32'(bus.aluOperationD), 32'd0);
    chk("rst.we",  32'(bus.regWriteEnD),   32'd0);
    chk("rst.rd",  32'(bus.rdD),           32'd0);
    chk("rst.rs1", bus.rs1D,               32'd0);
    chk("rst.rs2", bus.rs2D,               32'd0);

    resetn = 1'b1;
    #1;
    chk("addi.alu", 32'(bus.aluOperationD), 32'd1);
    chk("addi.we",  32'(bus.regWriteEnD),   32'd1);
    chk("addi.rd",  32'(bus.rdD),           32'd5);
    chk("addi.rs1", bus.rs1D,               32'd0);

    // x5=1, x6=2 through the writeback port.
    drive_w(1'b1, 5'd5, 32'd1);
    step();
    drive_w(1'b1, 5'd6, 32'd2);
    step();
    drive_w(1'b0, 5'd0, 32'd0);
    bus.instructionD = 32'h0062_83b3;
    #1;
    chk("add.alu", 32'(bus.aluOperationD), 32'd1);
    chk("add.rs1", bus.rs1D,               32'd1);
    chk("add.rs2", bus.rs2D,               32'd2);
    chk("add.rd",  32'(bus.rdD),           32'd7);
    chk("add.we",  32'(bus.regWriteEnD),   32'd1);
    bus.instructionD = 32'h4062_83b3;
    #1;
    chk("sub.alu", 32'(bus.aluOperationD), 32'd2);
    chk("sub.rs1", bus.rs1D,               32'd1);
    chk("sub.rs2", bus.rs2D,               32'd2);
    step();

    foreach (zero_words[i]) begin
      bus.instructionD = zero_words[i];
      #1;
      chk($sformatf("ill%0d.alu", i), 32'(bus.aluOperationD), 32'd0);
      chk($sformatf("ill%0d.we", i),  32'(bus.regWriteEnD),   32'd0);
      chk($sformatf("ill%0d.rd", i),  32'(bus.rdD),           32'd0);
    end
    step();

    // Same-cycle writeback bypass.
    bus.instructionD = 32'h0062_83b3;
    drive_w(1'b1, 5'd5, 32'hDEAD_BEEF);
    #1;
    chk("byp.rs1", bus.rs1D, 32'hDEAD_BEEF);
    chk("byp.rs2", bus.rs2D, 32'd2);
    step();

    // Writes to x0 are discarded and x0 never bypasses.
    drive_w(1'b1, 5'd0, 32'h1234_5678);
    bus.instructionD = 32'h0000_0033;
    #1;
    chk("x0byp.rs1", bus.rs1D, 32'd0);
    step();
    drive_w(1'b0, 5'd0, 32'd0);
    #1;
    chk("x0.rs1", bus.rs1D,               32'd0);
    chk("x0.rs2", bus.rs2D,               32'd0);
    chk("x0.rd",  32'(bus.rdD),           32'd0);
    chk("x0.we",  32'(bus.regWriteEnD),   32'd1);

    // Random instructions and writebacks against the model.
    for (int n = 0; n < 400; n++) begin
      step();
      if ($urandom_range(0, 2) != 0) drive_w(1'b1, 5'($urandom_range(0, 31)), $urandom);
      else drive_w(1'b0, 5'($urandom_range(0, 31)), $urandom);
      bus.instructionD = rand_instr();
      #1;
      check_model($sformatf("rnd%0d", n));
    end

    // Asynchronous reset mid-run wipes the register file.
    step();
    drive_w(1'b1, 5'd5, 32'd1);
    step();
    drive_w(1'b0, 5'd0, 32'd0);
    bus.instructionD = 32'h0062_83b3;
    #1;
    chk("pre.rs1", bus.rs1D, 32'd1);
    #1;
    resetn = 1'b0;
    model_clear();
    #1;
    check_model("midrst");
    resetn = 1'b1;
    #1;
    chk("post.rs1", bus.rs1D,               32'd0);
    chk("post.alu", 32'(bus.aluOperationD), 32'd1);
    check_model("post");
    step();
    check_model("post2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
